ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage pipeline, consuming the ID/EX register outputs and producing the EX/MEM register. It contains operand forwarding, the single-cycle ALU, and a multi-cycle shift-add multiplier. While a multiply is in progress, it stalls the front end and inserts bubbles into EX/MEM.

## Interface

- Parameters: none; datapath is fixed at 32 bits.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- wb_i  in  2  WB control from ID/EX; [1]=RegWrite, [0]=MemtoReg
- m_i  in  2  M control from ID/EX; [1]=MemRead, [0]=MemWrite
- ex_i  in  4  EX control:
  - [3]=RegDst
  - [2]=ALUSrc
  - [1:0]=ALUOp (00 add, 01 sub, 10 R-type by funct)
- data1_i, data2_i  in  32  rs/rt register-file values
- signextend_i  in  32  sign-extended immediate; [5:0] is funct
- rs_i, rt_i, rd_i  in  5  register specifiers
- memwb_regwrite_i  in  1; memwb_rd_i  in  5; memwb_data_i  in  32  forwarding source from MEM/WB
- wb_o  out  2  registered EX/MEM WB control
- m_o  out  2  registered EX/MEM M control
- alu_result_o  out  32  registered ALU or multiply result
- wdata_o  out  32  registered store data (forwarded rt value)
- rd_o  out  5  registered destination register
- stall_o  out  1  combinational; freezes PC, IF/ID and ID/EX while high

## Operation

- **Forwarding (A=rs, B=rt), independently per operand.** Priority order:
  - EX/MEM when wb_o[1]=1, rd_o≠0 and rd_o matches → alu_result_o
  - else MEM/WB when memwb_regwrite_i=1, memwb_rd_i≠0 and matches → memwb_data_i
  - else data1_i/data2_i
- **Operand B** for the ALU is signextend_i when ALUSrc=1, else the forwarded rt. wdata_o always takes the forwarded rt.
- **Destination** is rd_i when RegDst=1, else rt_i.
- **R-type funct decode:**
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - 011000 mul
  - any other funct → add
- **Arithmetic:**
  - add/sub wrap modulo 2^32
  - slt is a signed compare → 32'd1 or 32'd0
  - mul yields the low 32 bits of the product
- **Multiplier FSM:**
  - IDLE:
    - With a non-mul instruction, there is no stall; EX/MEM loads the ALU result.
    - On mul (ALUOp=10, funct=011000): stall_o=1; latch forwarded A as multiplicand and B as multiplier; acc=0, cnt=0 → BUSY.
  - BUSY: stall_o=1. Each cycle:
    - if multiplier[0]=1, acc += multiplicand
    - multiplicand <<= 1
    - multiplier >>= 1
    - cnt++
    - after the 32nd BUSY cycle → DONE
  - DONE: stall_o=0, alu_result source = acc. EX/MEM captures acc with the mul's wb/m/rd → IDLE.
- **EX/MEM while stall_o=1:** load a bubble (wb_o=0, m_o=0, alu_result_o=0, wdata_o=0, rd_o=0).
- **Latched operands:** forwarding sources may change during a stall without affecting the result.

## Timing

- Reset (async, rst_i=0): FSM→IDLE; acc, cnt and operand latches cleared; all registered outputs 0; stall_o forced 0 while rst_i=0.
- Non-mul instruction: 1-cycle latency, ID/EX to EX/MEM on the next edge.
- mul: stall_o is high for 33 cycles (the IDLE-detect cycle plus 32 BUSY cycles). The result appears in alu_result_o at the edge ending DONE. The instruction occupies EX for 34 cycles.
- Back-to-back mul: the second mul is detected in the IDLE cycle after DONE and restarts the FSM with a fresh 33-cycle stall.
- Reset mid-multiply: aborts immediately; stall_o drops asynchronously; no partial result is written.
- Forwarding to the instruction following a mul: EX/MEM holds the mul result one cycle after DONE.
- Multiplier operand 0: still takes the full 32 BUSY cycles; result 0.

## Test plan

- **Reset:** hold rst_i=0 with any inputs → all outputs 0, stall_o=0. Release and issue add 5+7 with RegDst=1, rd=3 → next edge alu_result_o=12, rd_o=3, wb_o=wb_i.
- **EX/MEM forwarding:** add r1 then sub r2=r1-r1 → EX/MEM forwarding selected, alu_result_o=0. Repeat with a stale data1_i of 99 to confirm forwarding overrides it.
- **MEM/WB forwarding and rd=0:**
  - memwb_rd_i=4, data 0x10; instruction "or rs=4" with rt value 0x01 → 0x11.
  - Same setup but EX/MEM also targets r4 → EX/MEM value wins.
  - rd=0 sources are never forwarded.
- **slt and immediate:**
  - slt with -1 vs 1 → 1
  - slt with 1 vs -1 → 0
  - ALUSrc=1, ALUOp=00, imm=0xFFFFFFFC, rs=8 → 4
- **Multiply:**
  - mul 0x0001_0003 × 0x0000_0005 → stall_o high exactly 33 cycles, EX/MEM bubbles throughout, then alu_result_o=0x0005_000F.
  - mul 0xFFFFFFFF × 0xFFFFFFFF → 1.
- **Reset mid-multiply and back-to-back mul:**
  - Assert rst_i at BUSY cycle 10 → outputs 0, stall_o 0. After release, a non-mul instruction completes normally.
  - Two consecutive muls → two 33-cycle stalls, both results correct.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, and a 32-cycle shift-add
// multiplier that stalls the front end and bubbles EX/MEM while it runs.
`default_nettype none

module ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  wb_i,
    input  logic [1:0]  m_i,
    input  logic [3:0]  ex_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [31:0] signextend_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic        memwb_regwrite_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_data_i,
    output logic [1:0]  wb_o,
    output logic [1:0]  m_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  rd_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    state_t      state;
    state_t      state_nxt;
    logic        stall_raw;
    logic        is_mul;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [4:0]  dest;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  cnt;

    // EX/MEM has priority over MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_a = data1_i;
        if (wb_o[1] && (rd_o != 5'd0) && (rd_o == rs_i))
            fwd_a = alu_result_o;
        else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_i))
            fwd_a = memwb_data_i;

        fwd_b = data2_i;
        if (wb_o[1] && (rd_o != 5'd0) && (rd_o == rt_i))
            fwd_b = alu_result_o;
        else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rt_i))
            fwd_b = memwb_data_i;
    end

    assign op_b   = ex_i[2] ? signextend_i : fwd_b;
    assign dest   = ex_i[3] ? rd_i : rt_i;
    assign is_mul = (ex_i[1:0] == 2'b10) && (signextend_i[5:0] == FN_MUL);

    always_comb begin
        alu_res = fwd_a + op_b;
        case (ex_i[1:0])
            2'b01: alu_res = fwd_a - op_b;
            2'b10: begin
                case (signextend_i[5:0])
                    FN_ADD:  alu_res = fwd_a + op_b;
                    FN_SUB:  alu_res = fwd_a - op_b;
                    FN_AND:  alu_res = fwd_a & op_b;
                    FN_OR:   alu_res = fwd_a | op_b;
                    FN_SLT:  alu_res = ($signed(fwd_a) < $signed(op_b)) ? 32'd1 : 32'd0;
                    default: alu_res = fwd_a + op_b;
                endcase
            end
            default: alu_res = fwd_a + op_b;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    stall_raw = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_raw = 1'b1;
                if (cnt == 5'd31)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with rst_i lets the stall drop the instant reset asserts.
    assign stall_o = stall_raw & rst_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            cnt    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        mcand  <= fwd_a;
                        mplier <= op_b;
                        acc    <= 32'd0;
                        cnt    <= 5'd0;
                    end
                end
                BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_o         <= 2'd0;
            m_o          <= 2'd0;
            alu_result_o <= 32'd0;
            wdata_o      <= 32'd0;
            rd_o         <= 5'd0;
        end else if (stall_o) begin
            wb_o         <= 2'd0;
            m_o          <= 2'd0;
            alu_result_o <= 32'd0;
            wdata_o      <= 32'd0;
            rd_o         <= 5'd0;
        end else begin
            wb_o         <= wb_i;
            m_o          <= m_i;
            alu_result_o <= (state == DONE) ? acc : alu_res;
            wdata_o      <= fwd_b;
            rd_o         <= dest;
        end
    end

endmodule

`default_nettype wire
